// File: rtl/uart_alu_cmd_sender_if.sv
// Command and UART-FIFO signal bundle for the ALU command sender.
// The master modport is the sender; the slave modport is the host controller plus the UART FIFOs.
interface uart_alu_cmd_sender_if #(
   parameter int DATA_BITS   = 8,
   parameter int OPCODE_BITS = 6
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [DATA_BITS-1:0]   op_a;
   logic [DATA_BITS-1:0]   op_b;
   logic [OPCODE_BITS-1:0] op_code;
   logic [DATA_BITS-1:0]   w_data;
   logic                   wr_uart;
   logic                   tx_full;
   logic [DATA_BITS-1:0]   r_data;
   logic                   rx_empty;
   logic                   rd_uart;
   logic [DATA_BITS-1:0]   result;
   logic                   result_valid;
   logic                   timeout;
   logic                   busy;

   modport master (
      input  cmd_valid, op_a, op_b, op_code, tx_full, r_data, rx_empty,
      output cmd_ready, w_data, wr_uart, rd_uart, result, result_valid, timeout, busy
   );

   modport slave (
      output cmd_valid, op_a, op_b, op_code, tx_full, r_data, rx_empty,
      input  cmd_ready, w_data, wr_uart, rd_uart, result, result_valid, timeout, busy
   );
endinterface

// File: rtl/uart_alu_cmd_sender.sv
// Host-side ALU command initiator: sends A, B, OPCODE bytes to the UART TX FIFO,
// then waits (bounded) for one result byte from the RX FIFO.
module uart_alu_cmd_sender #(
   parameter int DATA_BITS      = 8,
   parameter int OPCODE_BITS    = 6,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   uart_alu_cmd_sender_if.master  bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      SEND_OP,
      WAIT_RESP,
      DONE
   } state_t;

   state_t               state_reg;
   logic [DATA_BITS-1:0] a_reg;
   logic [DATA_BITS-1:0] b_reg;
   logic [DATA_BITS-1:0] op_reg;
   logic [CNT_W-1:0]     cnt_reg;
   logic [DATA_BITS-1:0] result_reg;
   logic                 result_valid_reg;
   logic                 timeout_reg;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg        <= IDLE;
         a_reg            <= '0;
         b_reg            <= '0;
         op_reg           <= '0;
         cnt_reg          <= '0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         result_valid_reg <= 1'b0;
         timeout_reg      <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Stale RX bytes keep the block not-ready; they are popped combinationally.
               if (bus.rx_empty && bus.cmd_valid) begin
                  a_reg     <= bus.op_a;
                  b_reg     <= bus.op_b;
                  op_reg    <= DATA_BITS'(bus.op_code);
                  state_reg <= SEND_A;
               end
            end
            SEND_A: if (!bus.tx_full) state_reg <= SEND_B;
            SEND_B: if (!bus.tx_full) state_reg <= SEND_OP;
            SEND_OP: begin
               if (!bus.tx_full) begin
                  cnt_reg   <= '0;
                  state_reg <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // An arriving byte takes priority over the terminal count.
               if (!bus.rx_empty) begin
                  result_reg       <= bus.r_data;
                  result_valid_reg <= 1'b1;
                  state_reg        <= DONE;
               end else if (cnt_reg == CNT_TERM) begin
                  timeout_reg <= 1'b1;
                  state_reg   <= IDLE;
               end else if (cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.w_data    = '0;
      bus.wr_uart   = 1'b0;
      bus.rd_uart   = 1'b0;
      bus.cmd_ready = 1'b0;
      case (state_reg)
         IDLE: begin
            bus.rd_uart   = ~bus.rx_empty;
            bus.cmd_ready = bus.rx_empty;
         end
         SEND_A: begin
            bus.w_data  = a_reg;
            bus.wr_uart = ~bus.tx_full;
         end
         SEND_B: begin
            bus.w_data  = b_reg;
            bus.wr_uart = ~bus.tx_full;
         end
         SEND_OP: begin
            bus.w_data  = op_reg;
            bus.wr_uart = ~bus.tx_full;
         end
         WAIT_RESP: bus.rd_uart = ~bus.rx_empty;
         default: ;
      endcase
   end

   assign bus.result       = result_reg;
   assign bus.result_valid = result_valid_reg;
   assign bus.timeout      = timeout_reg;
   assign bus.busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_alu_cmd_sender.sv
// Directed bench for uart_alu_cmd_sender with TIMEOUT_CYCLES=16; the bench plays
// both the host controller and the UART FIFOs.
module tb_uart_alu_cmd_sender;
   logic clk;
   logic i_reset;
   int   checks;
   int   failures;
   int   viol_wr;
   int   viol_rd;

   uart_alu_cmd_sender_if #(.DATA_BITS(8), .OPCODE_BITS(6)) bus ();

   uart_alu_cmd_sender #(
      .DATA_BITS(8),
      .OPCODE_BITS(6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk   (clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobes must never fire against a full/empty FIFO flag.
   always @(posedge clk) begin
      if (bus.wr_uart && bus.tx_full) viol_wr++;
      if (bus.rd_uart && bus.rx_empty) viol_rd++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Handshake at cycle 0, checks the three TX writes; returns at cycle 4 (WAIT_RESP).
   task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           input string tag);
      logic [7:0] op_ext;
      op_ext = {2'b00, op};
      bus.cmd_valid = 1'b1;
      bus.op_a = a;
      bus.op_b = b;
      bus.op_code = op;
      #1 chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      chk({tag, "_wrA"}, 32'(bus.wr_uart), 32'd1);
      chk({tag, "_byteA"}, 32'(bus.w_data), 32'(a));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      tick();
      chk({tag, "_byteB"}, 32'(bus.w_data), 32'(b));
      tick();
      chk({tag, "_wrOP"}, 32'(bus.wr_uart), 32'd1);
      chk({tag, "_byteOP"}, 32'(bus.w_data), 32'(op_ext));
      tick();
      chk({tag, "_wait_nowr"}, 32'(bus.wr_uart), 32'd0);
   endtask

   // Response present in the current WAIT_RESP cycle; checks pop, valid pulse and return to ready.
   task automatic respond(input logic [7:0] resp, input string tag);
      bus.rx_empty = 1'b0;
      bus.r_data = resp;
      #1 chk({tag, "_pop"}, 32'(bus.rd_uart), 32'd1);
      tick();
      bus.rx_empty = 1'b1;
      #1;
      chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
      chk({tag, "_result"}, 32'(bus.result), 32'(resp));
      chk({tag, "_timeout0"}, 32'(bus.timeout), 32'd0);
      tick();
      chk({tag, "_valid_end"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_ready_again"}, 32'(bus.cmd_ready), 32'd1);
      $display("%s: result=%02h valid=%0b", tag, bus.result, bus.result_valid);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      viol_wr = 0;
      viol_rd = 0;
      i_reset = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.op_code = '0;
      bus.tx_full = 1'b0;
      bus.rx_empty = 1'b1;
      bus.r_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_timeout", 32'(bus.timeout), 32'd0);
      chk("rst_wr", 32'(bus.wr_uart), 32'd0);
      chk("rst_rd", 32'(bus.rd_uart), 32'd0);
      chk("rst_wdata", 32'(bus.w_data), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      i_reset = 1'b0;
      tick();

      // T1: plain command with immediate response
      send_cmd(8'h05, 8'h03, 6'h20, "T1");
      respond(8'h08, "T1");

      // T2: TX FIFO full for 10 cycles during SEND_B
      bus.cmd_valid = 1'b1;
      bus.op_a = 8'h11;
      bus.op_b = 8'h22;
      bus.op_code = 6'h3F;
      tick();
      bus.cmd_valid = 1'b0;
      chk("T2_byteA", 32'(bus.w_data), 32'h11);
      tick();
      bus.tx_full = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1 chk("T2_nowr_full", 32'(bus.wr_uart), 32'd0);
         tick();
      end
      bus.tx_full = 1'b0;
      #1;
      chk("T2_wrB", 32'(bus.wr_uart), 32'd1);
      chk("T2_byteB", 32'(bus.w_data), 32'h22);
      tick();
      chk("T2_byteOP", 32'(bus.w_data), 32'h3F);
      tick();
      respond(8'h33, "T2");

      // T3: silent responder, timeout after 16 WAIT_RESP cycles
      send_cmd(8'h40, 8'h02, 6'h01, "T3");
      for (int i = 0; i < 16; i++) begin
         chk("T3_no_timeout_yet", 32'(bus.timeout), 32'd0);
         chk("T3_busy_wait", 32'(bus.busy), 32'd1);
         tick();
      end
      chk("T3_timeout", 32'(bus.timeout), 32'd1);
      chk("T3_result_kept", 32'(bus.result), 32'h33);
      chk("T3_no_valid", 32'(bus.result_valid), 32'd0);
      chk("T3_idle", 32'(bus.busy), 32'd0);
      tick();
      chk("T3_timeout_end", 32'(bus.timeout), 32'd0);
      $display("T3: timeout seen, result held=%02h", bus.result);

      // T4: two stale bytes flushed before the command is accepted
      bus.rx_empty = 1'b0;
      bus.r_data = 8'hAA;
      bus.cmd_valid = 1'b1;
      bus.op_a = 8'h05;
      bus.op_b = 8'h03;
      bus.op_code = 6'h20;
      #1;
      chk("T4_notready1", 32'(bus.cmd_ready), 32'd0);
      chk("T4_flush1", 32'(bus.rd_uart), 32'd1);
      tick();
      bus.r_data = 8'hBB;
      #1;
      chk("T4_notready2", 32'(bus.cmd_ready), 32'd0);
      chk("T4_flush2", 32'(bus.rd_uart), 32'd1);
      chk("T4_not_taken", 32'(bus.busy), 32'd0);
      tick();
      bus.rx_empty = 1'b1;
      $display("T4: flushed stale bytes AA BB");
      send_cmd(8'h05, 8'h03, 6'h20, "T4");
      respond(8'h08, "T4");

      // T5: asynchronous reset while waiting for the response
      send_cmd(8'h12, 8'h34, 6'h05, "T5a");
      tick();
      #1 i_reset = 1'b1;
      #1;
      chk("T5_rst_result", 32'(bus.result), 32'd0);
      chk("T5_rst_busy", 32'(bus.busy), 32'd0);
      chk("T5_rst_wr", 32'(bus.wr_uart), 32'd0);
      chk("T5_rst_rd", 32'(bus.rd_uart), 32'd0);
      chk("T5_rst_valid", 32'(bus.result_valid), 32'd0);
      chk("T5_rst_timeout", 32'(bus.timeout), 32'd0);
      @(negedge clk);
      i_reset = 1'b0;
      tick();
      send_cmd(8'hFF, 8'h01, 6'h21, "T5");
      respond(8'hA5, "T5");

      // T6: byte lands on the terminal-count cycle and wins over the timeout
      send_cmd(8'h07, 8'h09, 6'h02, "T6");
      for (int i = 0; i < 15; i++) tick();
      chk("T6_still_waiting", 32'(bus.busy), 32'd1);
      respond(8'hC3, "T6");
      chk("T6_no_late_timeout", 32'(bus.timeout), 32'd0);

      chk("no_wr_while_full", 32'(viol_wr), 32'd0);
      chk("no_rd_while_empty", 32'(viol_rd), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
